// File: rtl/spi_dac_slave.sv
// SPI mode-0 DAC slave: synchronized SPI/LDAC inputs, framed word receive, LDAC-driven DAC register.
// Optional MSB-first readback of the DAC register on o_spi_sdo when SPI_DAC_SLAVE_READBACK_EN is defined.
module spi_dac_slave #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  i_clk,
    input  logic                  i_arst_n,
    input  logic                  i_spi_cs_n,
    input  logic                  i_spi_sclk,
    input  logic                  i_spi_sdi,
    input  logic                  i_ldac_n,
    output logic                  o_spi_sdo,
    output logic [DATA_WIDTH-1:0] o_rx_data,
    output logic                  o_rx_valid,
    output logic [DATA_WIDTH-1:0] o_dac_data,
    output logic                  o_dac_update,
    output logic                  o_frame_err
);

    localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_OVER = CNT_W'(DATA_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        CHECK
    } state_e;

    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] sdi_sync_q;
    logic [SYNC_STAGES-1:0] ldac_sync_q;
    logic                   cs_prev_q;
    logic                   sclk_prev_q;
    logic                   ldac_prev_q;
    logic                   ldac_fall_q;

    state_e                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [DATA_WIDTH-1:0]  shift_q;
    logic                   cs_pend_q;
    logic [DATA_WIDTH-1:0]  rx_data_q;
    logic                   rx_valid_q;
    logic [DATA_WIDTH-1:0]  dac_data_q;
    logic                   dac_update_q;
    logic                   frame_err_q;

    logic cs_s, sclk_s, sdi_s, ldac_s;
    logic cs_fall, cs_rise, sclk_rise, ldac_fall;
    logic start_frame, word_ok;

    assign cs_s        = cs_sync_q[SYNC_STAGES-1];
    assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    assign sdi_s       = sdi_sync_q[SYNC_STAGES-1];
    assign ldac_s      = ldac_sync_q[SYNC_STAGES-1];
    assign cs_fall     = cs_prev_q & ~cs_s;
    assign cs_rise     = ~cs_prev_q & cs_s;
    assign sclk_rise   = ~sclk_prev_q & sclk_s;
    assign ldac_fall   = ldac_prev_q & ~ldac_s;
    assign start_frame = (state_q == IDLE) && (cs_fall || cs_pend_q);
    assign word_ok     = (state_q == CHECK) && (cnt_q == CNT_FULL);

    // LDAC fall is delayed one cycle so it lines up with the CHECK cycle of a CS rise sampled at the same edge.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            cs_sync_q   <= '1;
            sclk_sync_q <= '0;
            sdi_sync_q  <= '0;
            ldac_sync_q <= '1;
            cs_prev_q   <= 1'b1;
            sclk_prev_q <= 1'b0;
            ldac_prev_q <= 1'b1;
            ldac_fall_q <= 1'b0;
        end else begin
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], i_spi_cs_n};
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], i_spi_sclk};
            sdi_sync_q  <= {sdi_sync_q[SYNC_STAGES-2:0], i_spi_sdi};
            ldac_sync_q <= {ldac_sync_q[SYNC_STAGES-2:0], i_ldac_n};
            cs_prev_q   <= cs_s;
            sclk_prev_q <= sclk_s;
            ldac_prev_q <= ldac_s;
            ldac_fall_q <= ldac_fall;
        end
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            shift_q      <= '0;
            cs_pend_q    <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            dac_data_q   <= '0;
            dac_update_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            rx_valid_q   <= 1'b0;
            dac_update_q <= 1'b0;
            frame_err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_frame) begin
                        state_q   <= RECV;
                        cnt_q     <= '0;
                        cs_pend_q <= 1'b0;
                    end
                end
                RECV: begin
                    if (cs_rise) begin
                        state_q <= CHECK;
                    end else if (sclk_rise) begin
                        shift_q <= {shift_q[DATA_WIDTH-2:0], sdi_s};
                        if (cnt_q != CNT_OVER) begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                CHECK: begin
                    state_q <= IDLE;
                    if (cs_fall) begin
                        cs_pend_q <= 1'b1;
                    end
                    if (cnt_q == CNT_FULL) begin
                        rx_data_q  <= shift_q;
                        rx_valid_q <= 1'b1;
                    end else if (cnt_q != '0) begin
                        frame_err_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (ldac_fall_q) begin
                dac_data_q   <= word_ok ? shift_q : rx_data_q;
                dac_update_q <= 1'b1;
            end
        end
    end

`ifdef SPI_DAC_SLAVE_READBACK_EN
    logic [DATA_WIDTH-1:0] sdo_sr_q;
    logic                  sclk_fall;

    assign sclk_fall = sclk_prev_q & ~sclk_s;

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            sdo_sr_q <= '0;
        end else if (start_frame) begin
            sdo_sr_q <= dac_data_q;
        end else if ((state_q == RECV) && sclk_fall) begin
            sdo_sr_q <= {sdo_sr_q[DATA_WIDTH-2:0], 1'b0};
        end
    end

    assign o_spi_sdo = sdo_sr_q[DATA_WIDTH-1];
`else
    assign o_spi_sdo = 1'b0;
`endif

    assign o_rx_data    = rx_data_q;
    assign o_rx_valid   = rx_valid_q;
    assign o_dac_data   = dac_data_q;
    assign o_dac_update = dac_update_q;
    assign o_frame_err  = frame_err_q;

endmodule

// File: tb/tb_spi_dac_slave.sv
// Scoreboard bench for spi_dac_slave: expected words queued at stimulus time, popped on rx/dac pulses.
module tb_spi_dac_slave;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cs_n = 1'b1;
    logic        sclk = 1'b0;
    logic        sdi = 1'b0;
    logic        ldac_n = 1'b1;
    logic        sdo;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic [15:0] dac_data;
    logic        dac_update;
    logic        frame_err;

    int unsigned n_checks = 0;
    int unsigned n_pass = 0;
    int unsigned n_rx = 0;
    int unsigned n_dac = 0;
    int unsigned n_err = 0;
    int unsigned n_both = 0;

    logic [15:0] rx_q[$];
    logic [15:0] dac_q[$];
    logic [15:0] rx_exp_w;
    logic [15:0] dac_exp_w;

    spi_dac_slave #(
        .DATA_WIDTH (16),
        .SYNC_STAGES(2)
    ) dut (
        .i_clk       (clk),
        .i_arst_n    (rst_n),
        .i_spi_cs_n  (cs_n),
        .i_spi_sclk  (sclk),
        .i_spi_sdi   (sdi),
        .i_ldac_n    (ldac_n),
        .o_spi_sdo   (sdo),
        .o_rx_data   (rx_data),
        .o_rx_valid  (rx_valid),
        .o_dac_data  (dac_data),
        .o_dac_update(dac_update),
        .o_frame_err (frame_err)
    );

    always #10 clk = ~clk;

    // Scoreboard monitor: every output pulse consumes one queued expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid) begin
                n_rx++;
                n_checks++;
                if (rx_q.size() == 0) begin
                    $display("FAIL rx_unexpected: got pulse with data %h, required no pulse", rx_data);
                end else begin
                    rx_exp_w = rx_q.pop_front();
                    if (rx_data !== rx_exp_w)
                        $display("FAIL rx_data: got %h, required %h", rx_data, rx_exp_w);
                    else
                        n_pass++;
                end
            end
            if (dac_update) begin
                n_dac++;
                n_checks++;
                if (dac_q.size() == 0) begin
                    $display("FAIL dac_unexpected: got pulse with data %h, required no pulse", dac_data);
                end else begin
                    dac_exp_w = dac_q.pop_front();
                    if (dac_data !== dac_exp_w)
                        $display("FAIL dac_data: got %h, required %h", dac_data, dac_exp_w);
                    else
                        n_pass++;
                end
            end
            if (frame_err) n_err++;
            if (rx_valid && dac_update) n_both++;
        end
    end

    task automatic settle();
        repeat (12) @(negedge clk);
    endtask

    // Mode-0 master; inputs change only on negedge clk so sampling is deterministic.
    task automatic spi_xfer(input logic [31:0] word, input int unsigned nbits,
                            input int unsigned hi, input int unsigned lo,
                            input bit end_cs, input bit ldac_at_end,
                            output logic [31:0] rb);
        rb = '0;
        @(negedge clk);
        cs_n = 1'b0;
        for (int unsigned i = 0; i < nbits; i++) begin
            sdi = word[nbits-1-i];
            repeat (lo) @(negedge clk);
            rb = {rb[30:0], sdo};
            sclk = 1'b1;
            repeat (hi) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (lo) @(negedge clk);
        if (end_cs) begin
            cs_n = 1'b1;
            if (ldac_at_end) ldac_n = 1'b0;
        end
    endtask

    task automatic ldac_pulse();
        @(negedge clk);
        ldac_n = 1'b0;
        repeat (5) @(negedge clk);
        ldac_n = 1'b1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks += 6;
        if (rx_data !== 16'h0000) $display("FAIL reset_rx_data: got %h, required 0000", rx_data); else n_pass++;
        if (dac_data !== 16'h0000) $display("FAIL reset_dac_data: got %h, required 0000", dac_data); else n_pass++;
        if (rx_valid !== 1'b0) $display("FAIL reset_rx_valid: got %b, required 0", rx_valid); else n_pass++;
        if (dac_update !== 1'b0) $display("FAIL reset_dac_update: got %b, required 0", dac_update); else n_pass++;
        if (frame_err !== 1'b0) $display("FAIL reset_frame_err: got %b, required 0", frame_err); else n_pass++;
        if (sdo !== 1'b0) $display("FAIL reset_sdo: got %b, required 0", sdo); else n_pass++;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_rx_frame();
        logic [31:0] rb;
        int unsigned rx0 = n_rx;
        rx_q.push_back(16'hA55A);
        spi_xfer(32'hA55A, 16, 2, 3, 1'b1, 1'b0, rb);
        settle();
        n_checks += 3;
        if (n_rx - rx0 !== 1) $display("FAIL rx_pulse_count: got %0d, required 1", n_rx - rx0); else n_pass++;
        if (rx_data !== 16'hA55A) $display("FAIL rx_hold: got %h, required a55a", rx_data); else n_pass++;
        if (dac_data !== 16'h0000) $display("FAIL dac_untouched: got %h, required 0000", dac_data); else n_pass++;
    endtask

    task automatic test_ldac();
        logic [31:0] rb;
        int unsigned dac0;
        rx_q.push_back(16'h1234);
        spi_xfer(32'h1234, 16, 2, 3, 1'b1, 1'b0, rb);
        settle();
        dac0 = n_dac;
        dac_q.push_back(16'h1234);
        ldac_pulse();
        settle();
        n_checks += 2;
        if (n_dac - dac0 !== 1) $display("FAIL dac_pulse_count: got %0d, required 1", n_dac - dac0); else n_pass++;
        if (dac_data !== 16'h1234) $display("FAIL dac_hold: got %h, required 1234", dac_data); else n_pass++;
    endtask

    task automatic test_frame_err();
        logic [31:0] rb;
        int unsigned err0 = n_err;
        int unsigned rx0 = n_rx;
        spi_xfer(32'h0ABC, 12, 2, 3, 1'b1, 1'b0, rb);
        settle();
        spi_xfer(32'h1FFFF, 17, 2, 3, 1'b1, 1'b0, rb);
        settle();
        n_checks += 3;
        if (n_err - err0 !== 2) $display("FAIL frame_err_count: got %0d, required 2", n_err - err0); else n_pass++;
        if (n_rx - rx0 !== 0) $display("FAIL bad_frame_rx_count: got %0d, required 0", n_rx - rx0); else n_pass++;
        if (rx_data !== 16'h1234) $display("FAIL bad_frame_rx_keep: got %h, required 1234", rx_data); else n_pass++;
    endtask

    task automatic test_ldac_coincide();
        logic [31:0] rb;
        int unsigned both0 = n_both;
        rx_q.push_back(16'h00FF);
        dac_q.push_back(16'h00FF);
        spi_xfer(32'h00FF, 16, 2, 3, 1'b1, 1'b1, rb);
        repeat (5) @(negedge clk);
        ldac_n = 1'b1;
        settle();
        n_checks += 2;
        if (n_both - both0 !== 1) $display("FAIL coincide_same_cycle: got %0d, required 1", n_both - both0); else n_pass++;
        if (dac_data !== 16'h00FF) $display("FAIL coincide_dac: got %h, required 00ff", dac_data); else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] rb;
        int unsigned err0;
        spi_xfer(32'hBE, 8, 2, 3, 1'b0, 1'b0, rb);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        cs_n = 1'b1;
        sdi = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        n_checks += 2;
        if (rx_data !== 16'h0000) $display("FAIL midrst_rx_clear: got %h, required 0000", rx_data); else n_pass++;
        if (dac_data !== 16'h0000) $display("FAIL midrst_dac_clear: got %h, required 0000", dac_data); else n_pass++;
        err0 = n_err;
        rx_q.push_back(16'h0001);
        spi_xfer(32'h0001, 16, 2, 3, 1'b1, 1'b0, rb);
        settle();
        n_checks += 2;
        if (n_err - err0 !== 0) $display("FAIL midrst_err: got %0d, required 0", n_err - err0); else n_pass++;
        if (rx_data !== 16'h0001) $display("FAIL midrst_rx: got %h, required 0001", rx_data); else n_pass++;
    endtask

    task automatic test_cs_low_at_release();
        logic [31:0] rb;
        int unsigned err0 = n_err;
        @(negedge clk);
        rst_n = 1'b0;
        cs_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rx_q.push_back(16'h5A0F);
        spi_xfer(32'h5A0F, 16, 2, 3, 1'b1, 1'b0, rb);
        settle();
        n_checks += 2;
        if (n_err - err0 !== 0) $display("FAIL lowcs_err: got %0d, required 0", n_err - err0); else n_pass++;
        if (rx_data !== 16'h5A0F) $display("FAIL lowcs_rx: got %h, required 5a0f", rx_data); else n_pass++;
    endtask

    task automatic test_readback();
        logic [31:0] rb;
        logic [15:0] exp_rb;
`ifdef SPI_DAC_SLAVE_READBACK_EN
        exp_rb = 16'hC3C3;
`else
        exp_rb = 16'h0000;
`endif
        rx_q.push_back(16'hC3C3);
        spi_xfer(32'hC3C3, 16, 2, 3, 1'b1, 1'b0, rb);
        settle();
        dac_q.push_back(16'hC3C3);
        ldac_pulse();
        settle();
        rx_q.push_back(16'h0000);
        spi_xfer(32'h0000, 16, 4, 4, 1'b1, 1'b0, rb);
        settle();
        n_checks += 2;
        if (rb[15:0] !== exp_rb) $display("FAIL readback_sdo: got %h, required %h", rb[15:0], exp_rb); else n_pass++;
        if (dac_data !== 16'hC3C3) $display("FAIL readback_dac_keep: got %h, required c3c3", dac_data); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_rx_frame();
        test_ldac();
        test_frame_err();
        test_ldac_coincide();
        test_reset_mid_frame();
        test_cs_low_at_release();
        test_readback();
        n_checks += 2;
        if (rx_q.size() != 0) $display("FAIL rx_missing: got %0d pending, required 0", rx_q.size()); else n_pass++;
        if (dac_q.size() != 0) $display("FAIL dac_missing: got %0d pending, required 0", dac_q.size()); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
